// File: rtl/uart_tx_arbiter_if.sv
// Requester byte-stream bus plus the uart transmit handshake shared by the arbiter.
// master: the arbiter; slave: the requesters and the uart as seen from outside.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_transmit;
  logic [7:0]           uart_tx_byte;
  logic                 uart_is_transmitting;

  modport master (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  uart_is_transmitting,
    output req_ready,
    output uart_transmit,
    output uart_tx_byte
  );

  modport slave (
    output req_valid,
    output req_data,
    output req_last,
    output uart_is_transmitting,
    input  req_ready,
    input  uart_transmit,
    input  uart_tx_byte
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one uart transmitter between NUM_REQ
// byte-stream requesters, with a watchdog on the uart start handshake.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.master  bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout_err
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_SELECT,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE
  } state_t;

  state_t            state, nxt_state;
  logic              lock, nxt_lock;
  logic [IW-1:0]     last_owner, nxt_last;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [7:0]        tx_byte_q, nxt_byte;
  logic              transmit_q, nxt_transmit;
  logic [NUM_REQ-1:0] nxt_grant;
  logic              nxt_busy;
  logic              nxt_timeout;
  logic [NUM_REQ-1:0] ready_c;

  logic              rr_found;
  logic [IW-1:0]     rr_sel;
  logic              take;
  logic [IW-1:0]     pick;

  // First valid requester after last_owner, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    logic [IW-1:0] cand;
    rr_found = 1'b0;
    rr_sel   = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_owner) + k) % NUM_REQ);
      if (!rr_found && bus.req_valid[cand]) begin
        rr_found = 1'b1;
        rr_sel   = cand;
      end
    end
  end

  // Next-state and next-register values; req_ready is the only combinational output.
  always_comb begin : fsm_comb
    nxt_state   = state;
    nxt_lock    = lock;
    nxt_last    = last_owner;
    nxt_cnt     = cnt;
    nxt_byte    = tx_byte_q;
    nxt_grant   = grant;
    nxt_timeout = 1'b0;
    ready_c     = '0;
    take        = 1'b0;
    pick        = '0;

    case (state)
      S_SELECT: begin
        if (lock) begin
          take = bus.req_valid[last_owner];
          pick = last_owner;
        end else begin
          take = rr_found;
          pick = rr_sel;
        end
        if (take) begin
          ready_c[pick] = 1'b1;
          nxt_byte      = bus.req_data[{pick, 3'b000} +: 8];
          nxt_grant     = NUM_REQ'(1) << pick;
          nxt_last      = pick;
          nxt_lock      = ~bus.req_last[pick];
          nxt_cnt       = '0;
          nxt_state     = S_ISSUE;
        end else if (!lock) begin
          nxt_grant = '0;
        end
      end

      // The counter measures cycles since the transmit pulse, so it runs here too.
      S_ISSUE: begin
        nxt_cnt   = cnt + CW'(1);
        nxt_state = S_WAIT_START;
      end

      S_WAIT_START: begin
        if (bus.uart_is_transmitting) begin
          nxt_state = S_WAIT_DONE;
        end else if (cnt == CW'(START_TIMEOUT - 1)) begin
          nxt_timeout = 1'b1;
          nxt_lock    = 1'b0;
          nxt_grant   = '0;
          nxt_state   = S_SELECT;
        end else begin
          nxt_cnt = cnt + CW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!bus.uart_is_transmitting) begin
          nxt_state = S_SELECT;
          if (!lock) begin
            nxt_grant = '0;
          end
        end
      end

      default: begin
        nxt_state = S_SELECT;
      end
    endcase

    nxt_transmit = (nxt_state == S_ISSUE);
    nxt_busy     = (nxt_state != S_SELECT) || nxt_lock;
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state       <= S_SELECT;
      lock        <= 1'b0;
      last_owner  <= IW'(NUM_REQ - 1);
      cnt         <= '0;
      tx_byte_q   <= 8'h00;
      transmit_q  <= 1'b0;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= nxt_state;
      lock        <= nxt_lock;
      last_owner  <= nxt_last;
      cnt         <= nxt_cnt;
      tx_byte_q   <= nxt_byte;
      transmit_q  <= nxt_transmit;
      grant       <= nxt_grant;
      busy        <= nxt_busy;
      timeout_err <= nxt_timeout;
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.uart_transmit = transmit_q;
  assign bus.uart_tx_byte  = tx_byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet traffic
// checked against a packet-level round-robin order model and a uart model.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ       = 4;
  localparam int unsigned START_TIMEOUT = 16;
  localparam int unsigned DEPTH         = 32;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               timeout_err;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant      (grant),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Directed drive (initial block) and producer drive (random/packet phases).
  logic [NUM_REQ-1:0]   d_valid = '0;
  logic [NUM_REQ-1:0]   d_last  = '0;
  logic [8*NUM_REQ-1:0] d_data  = '0;
  logic [NUM_REQ-1:0]   p_valid = '0;
  logic [NUM_REQ-1:0]   p_last  = '0;
  logic [8*NUM_REQ-1:0] p_data  = '0;
  bit                   prod_en = 1'b0;
  logic                 u_busy  = 1'b0;

  assign bus.req_valid            = prod_en ? p_valid : d_valid;
  assign bus.req_last             = prod_en ? p_last  : d_last;
  assign bus.req_data             = prod_en ? p_data  : d_data;
  assign bus.uart_is_transmitting = u_busy;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Uart model: start delay then a busy frame; it must never see overlapping pulses.
  bit uart_dead  = 1'b0;
  bit uart_rand  = 1'b0;
  int uart_delay = 1;
  int uart_frame = 10;
  bit u_pending  = 1'b0;
  int u_cnt      = 0;

  always @(negedge clk) begin
    if (bus.uart_transmit) begin
      checks++;
      assert (!u_busy && !u_pending)
      else begin
        errors++;
        $error("FAIL uart_overlap: observed=1 expected=0");
      end
      obs_q.push_back(bus.uart_tx_byte);
      if (!uart_dead) begin
        u_pending = 1'b1;
        u_cnt     = uart_rand ? int'($urandom_range(0, 5)) : uart_delay;
      end
    end else if (u_pending) begin
      if (u_cnt == 0) begin
        u_pending = 1'b0;
        u_busy    = 1'b1;
        u_cnt     = uart_rand ? int'($urandom_range(1, 12)) : uart_frame;
      end else begin
        u_cnt--;
      end
    end else if (u_busy) begin
      if (u_cnt <= 1) u_busy = 1'b0;
      else u_cnt--;
    end
  end

  // Producers: each requester streams its buffered bytes; gaps only inside packets.
  bit                 prod_gaps = 1'b1;
  int                 rd [NUM_REQ];
  int                 wr [NUM_REQ];
  int                 gap[NUM_REQ];
  logic [8:0]         pbuf[NUM_REQ][DEPTH];
  logic [NUM_REQ-1:0] fire = '0;

  always @(negedge clk) begin
    if (prod_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i]) begin
          rd[i]++;
          gap[i] = (rd[i] < wr[i] && !pbuf[i][rd[i]-1][8] && prod_gaps) ?
                   int'($urandom_range(0, 3)) : 0;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
        p_valid[i] = (rd[i] < wr[i]) && (gap[i] == 0);
        if (rd[i] < wr[i]) begin
          p_data[8*i +: 8] = pbuf[i][rd[i]][7:0];
          p_last[i]        = pbuf[i][rd[i]][8];
        end
      end
      #1;
      fire = p_valid & bus.req_ready;
    end else begin
      fire = '0;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input int i, input logic [7:0] b, input logic l);
    pbuf[i][wr[i]] = {l, b};
    wr[i]++;
  endtask

  task automatic clear_prod();
    for (int i = 0; i < NUM_REQ; i++) begin
      rd[i] = 0; wr[i] = 0; gap[i] = 0;
    end
  endtask

  function automatic bit prod_done();
    for (int i = 0; i < NUM_REQ; i++) if (rd[i] < wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || u_busy || u_pending || !prod_done()) && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_idle"}, 32'(n < budget), 32'd1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      chk($sformatf("%s_byte%0d", tag, k), 32'(obs_q[k]), 32'(exp_q[k]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_packets(input string tag);
    prod_en = 1'b1;
    wait_idle(tag, 6000);
    prod_en = 1'b0;
    cyc();
    clear_prod();
    chk_stream(tag);
  endtask

  // Directed single-byte handoff from requester i; returns in the issue cycle.
  task automatic send(input int i, input logic [7:0] b, input logic l);
    int n = 0;
    d_valid[i]       = 1'b1;
    d_data[8*i +: 8] = b;
    d_last[i]        = l;
    #1;
    while (!bus.req_ready[i] && n < 500) begin
      cyc();
      #1;
      n++;
    end
    chk($sformatf("send%0d_accept", i), 32'(n < 500), 32'd1);
    cyc();
    d_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Packet-level round robin: whole packets in pointer order, starting after NUM_REQ-1.
  task automatic build_expected();
    int pos[NUM_REQ];
    int p = NUM_REQ - 1;
    int sel;
    bit found;
    for (int i = 0; i < NUM_REQ; i++) pos[i] = rd[i];
    do begin
      found = 1'b0;
      sel   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!found && pos[(p + k) % NUM_REQ] < wr[(p + k) % NUM_REQ]) begin
          found = 1'b1;
          sel   = (p + k) % NUM_REQ;
        end
      end
      if (found) begin
        do begin
          exp_q.push_back(pbuf[sel][pos[sel]][7:0]);
          pos[sel]++;
        end while (!pbuf[sel][pos[sel]-1][8]);
        p = sel;
      end
    end while (found);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int np;
    int len;

    // 1: reset values, then a single-byte packet from requester 0.
    cyc();
    cyc();
    chk("rst_ready",    32'(bus.req_ready),     32'h0);
    chk("rst_transmit", 32'(bus.uart_transmit), 32'h0);
    chk("rst_tx_byte",  32'(bus.uart_tx_byte),  32'h00);
    chk("rst_grant",    32'(grant),             32'h0);
    chk("rst_busy",     32'(busy),              32'h0);
    chk("rst_timeout",  32'(timeout_err),       32'h0);
    rst_n = 1'b1;
    cyc();
    uart_delay = 0;
    uart_frame = 40;
    d_valid = 4'b0001; d_data[7:0] = 8'hA5; d_last = 4'b0001;
    #1;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    d_valid = '0;
    #1;
    chk("t1_ready_drop", 32'(bus.req_ready),     32'h0);
    chk("t1_transmit",   32'(bus.uart_transmit), 32'h1);
    chk("t1_tx_byte",    32'(bus.uart_tx_byte),  32'hA5);
    chk("t1_grant",      32'(grant),             32'h1);
    chk("t1_busy",       32'(busy),              32'h1);
    cyc();
    chk("t1_pulse_end", 32'(bus.uart_transmit), 32'h0);
    wait_idle("t1", 100);
    chk("t1_grant_end", 32'(grant), 32'h0);
    chk("t1_busy_end",  32'(busy),  32'h0);
    exp_q = '{8'hA5};
    chk_stream("t1");
    uart_delay = 1;
    uart_frame = 10;

    // 2: three simultaneous single-byte packets, then the pointer continues at 3.
    do_reset();
    load(0, 8'h11, 1'b1); load(1, 8'h22, 1'b1); load(2, 8'h33, 1'b1);
    exp_q = '{8'h11, 8'h22, 8'h33};
    run_packets("t2a");
    load(3, 8'h44, 1'b1); load(0, 8'h55, 1'b1);
    exp_q = '{8'h44, 8'h55};
    run_packets("t2b");

    // 3: a multi-byte packet is not interleaved with a waiting requester.
    load(1, 8'h01, 1'b0); load(1, 8'h02, 1'b0); load(1, 8'h03, 1'b1);
    load(2, 8'hFF, 1'b1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'hFF};
    run_packets("t3");

    // 4: locked owner stalls; the other requester must be ignored.
    send(1, 8'h10, 1'b0);
    d_valid[0] = 1'b1; d_data[7:0] = 8'h20; d_last[0] = 1'b1;
    repeat (30) cyc();
    for (int c = 0; c < 100; c++) begin
      cyc();
      #1;
      chk("t4_grant",    32'(grant),               32'h2);
      chk("t4_ready0",   32'(bus.req_ready[0]),    32'h0);
      chk("t4_transmit", 32'(bus.uart_transmit),   32'h0);
    end
    send(1, 8'h11, 1'b1);
    send(0, 8'h20, 1'b1);
    wait_idle("t4", 200);
    exp_q = '{8'h10, 8'h11, 8'h20};
    chk_stream("t4");

    // 5: uart never starts; watchdog fires and the next requester is served.
    uart_dead  = 1'b1;
    d_valid[2] = 1'b1; d_data[23:16] = 8'h40; d_last[2] = 1'b1;
    send(1, 8'h30, 1'b0);
    chk("t5_transmit", 32'(bus.uart_transmit), 32'h1);
    n = 0;
    while (!timeout_err && n < 40) begin
      cyc();
      n++;
    end
    chk("t5_latency", 32'(n), 32'(START_TIMEOUT));
    #1;
    chk("t5_grant", 32'(grant),         32'h0);
    chk("t5_busy",  32'(busy),          32'h0);
    chk("t5_ready", 32'(bus.req_ready), 32'h4);
    uart_dead = 1'b0;
    cyc();
    d_valid[2] = 1'b0;
    chk("t5_pulse_once", 32'(timeout_err),       32'h0);
    chk("t5_grant_next", 32'(grant),             32'h4);
    chk("t5_tx_next",    32'(bus.uart_tx_byte),  32'h40);
    chk("t5_tr_next",    32'(bus.uart_transmit), 32'h1);
    wait_idle("t5", 200);
    exp_q = '{8'h30, 8'h40};
    chk_stream("t5");

    // 6: asynchronous reset while a locked packet is on the wire.
    uart_frame = 20;
    send(3, 8'h50, 1'b0);
    n = 0;
    while (!u_busy && n < 20) begin
      cyc();
      n++;
    end
    chk("t6_uart_started", 32'(n < 20), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_grant",    32'(grant),             32'h0);
    chk("t6_busy",     32'(busy),              32'h0);
    chk("t6_transmit", 32'(bus.uart_transmit), 32'h0);
    chk("t6_tx_byte",  32'(bus.uart_tx_byte),  32'h00);
    chk("t6_timeout",  32'(timeout_err),       32'h0);
    chk("t6_ready",    32'(bus.req_ready),     32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    n = 0;
    while (u_busy && n < 60) begin
      cyc();
      n++;
    end
    d_data[7:0] = 8'h60; d_data[23:16] = 8'h70; d_last = 4'b0101; d_valid = 4'b0101;
    #1;
    chk("t6_first_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    d_valid[0] = 1'b0;
    chk("t6_first_grant", 32'(grant), 32'h1);
    send(2, 8'h70, 1'b1);
    wait_idle("t6", 200);
    exp_q = '{8'h50, 8'h60, 8'h70};
    chk_stream("t6");
    uart_frame = 10;

    // Randomized packets, random gaps and random uart timing against the order model.
    uart_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      clear_prod();
      for (int i = 0; i < NUM_REQ; i++) begin
        np = (i == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++) load(i, 8'($urandom), 1'(b == len - 1));
        end
      end
      build_expected();
      run_packets($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
